// File: rtl/hilo_mdu.sv
// HI/LO multiply-divide unit: signed/unsigned multiply and divide plus HI/LO moves.
// Latency: multiply MUL_LAT cycles, divide WIDTH+1 cycles, MTHI/MTLO commit at the accepting edge.
// Backpressure: busy is high while a multiply/divide is in flight; requests arriving then are dropped.
module hilo_mdu #(
  parameter int WIDTH   = 32,
  parameter int MUL_LAT = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             op_valid,
  input  logic [2:0]       op,
  input  logic [WIDTH-1:0] src_a,
  input  logic [WIDTH-1:0] src_b,
  input  logic             cancel,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] hi_out,
  output logic [WIDTH-1:0] lo_out
);

  // Counter must reach WIDTH-1 (divide steps) and MUL_LAT-1 (multiply wait).
  localparam int CW = $clog2(WIDTH) + 1;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_MUL  = 2'd1,
    S_DIV  = 2'd2,
    S_FIX  = 2'd3
  } state_e;

  state_e           state_q, state_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [WIDTH-1:0] hi_q, hi_d;
  logic [WIDTH-1:0] lo_q, lo_d;
  logic             done_q, done_d;
  // opa: multiplicand, or dividend shifting out / quotient shifting in.
  logic [WIDTH-1:0] opa_q, opa_d;
  // opb: multiplier, or divisor magnitude.
  logic [WIDTH-1:0] opb_q, opb_d;
  logic [WIDTH-1:0] rem_q, rem_d;
  logic             msgn_q, msgn_d;   // signed multiply
  logic             qneg_q, qneg_d;   // negate quotient at FIX
  logic             rneg_q, rneg_d;   // negate remainder at FIX

  // Multiply datapath: operands extended to 2*WIDTH so one unsigned multiply
  // yields the correct low 2*WIDTH bits for both signed and unsigned forms.
  logic [2*WIDTH-1:0] mul_a_ext, mul_b_ext, prod;
  assign mul_a_ext = msgn_q ? {{WIDTH{opa_q[WIDTH-1]}}, opa_q} : {{WIDTH{1'b0}}, opa_q};
  assign mul_b_ext = msgn_q ? {{WIDTH{opb_q[WIDTH-1]}}, opb_q} : {{WIDTH{1'b0}}, opb_q};
  assign prod      = mul_a_ext * mul_b_ext;

  // Restoring divide step: shift next dividend bit into the partial remainder
  // and subtract the divisor; the borrow bit decides the quotient bit.
  logic [WIDTH:0] rem_sh, rem_sub;
  assign rem_sh  = {rem_q, opa_q[WIDTH-1]};
  assign rem_sub = rem_sh - {1'b0, opb_q};

  // Operand magnitudes for the signed divide; opcode bit 0 clear means signed.
  logic             div_sgn;
  logic             a_neg, b_neg;
  logic [WIDTH-1:0] a_abs, b_abs;
  assign div_sgn = ~op[0];
  assign a_neg   = div_sgn & src_a[WIDTH-1];
  assign b_neg   = div_sgn & src_b[WIDTH-1];
  assign a_abs   = a_neg ? (~src_a + 1'b1) : src_a;
  assign b_abs   = b_neg ? (~src_b + 1'b1) : src_b;

  // Next-state and datapath updates; cancel always returns to IDLE without writing.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    hi_d    = hi_q;
    lo_d    = lo_q;
    done_d  = 1'b0;
    opa_d   = opa_q;
    opb_d   = opb_q;
    rem_d   = rem_q;
    msgn_d  = msgn_q;
    qneg_d  = qneg_q;
    rneg_d  = rneg_q;
    case (state_q)
      S_IDLE: begin
        if (op_valid && !cancel) begin
          case (op)
            3'b000, 3'b001: begin
              state_d = S_MUL;
              cnt_d   = '0;
              opa_d   = src_a;
              opb_d   = src_b;
              msgn_d  = ~op[0];
            end
            3'b010, 3'b011: begin
              state_d = S_DIV;
              cnt_d   = '0;
              opa_d   = a_abs;
              opb_d   = b_abs;
              rem_d   = '0;
              qneg_d  = a_neg ^ b_neg;
              rneg_d  = a_neg;
            end
            3'b100:  hi_d = src_a;
            3'b101:  lo_d = src_a;
            default: ;
          endcase
        end
      end
      S_MUL: begin
        if (cancel) begin
          state_d = S_IDLE;
        end else if (cnt_q == CW'(MUL_LAT - 1)) begin
          state_d = S_IDLE;
          hi_d    = prod[2*WIDTH-1:WIDTH];
          lo_d    = prod[WIDTH-1:0];
          done_d  = 1'b1;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      S_DIV: begin
        if (cancel) begin
          state_d = S_IDLE;
        end else begin
          if (!rem_sub[WIDTH]) begin
            rem_d = rem_sub[WIDTH-1:0];
            opa_d = {opa_q[WIDTH-2:0], 1'b1};
          end else begin
            rem_d = rem_sh[WIDTH-1:0];
            opa_d = {opa_q[WIDTH-2:0], 1'b0};
          end
          if (cnt_q == CW'(WIDTH - 1)) begin
            state_d = S_FIX;
          end else begin
            cnt_d = cnt_q + CW'(1);
          end
        end
      end
      S_FIX: begin
        state_d = S_IDLE;
        if (!cancel) begin
          done_d = 1'b1;
          // A zero divisor still completes, but leaves HI/LO untouched.
          if (opb_q != '0) begin
            lo_d = qneg_q ? (~opa_q + 1'b1) : opa_q;
            hi_d = rneg_q ? (~rem_q + 1'b1) : rem_q;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // State and datapath registers with asynchronous reset to an idle, zeroed unit.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      hi_q    <= '0;
      lo_q    <= '0;
      done_q  <= 1'b0;
      opa_q   <= '0;
      opb_q   <= '0;
      rem_q   <= '0;
      msgn_q  <= 1'b0;
      qneg_q  <= 1'b0;
      rneg_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
      done_q  <= done_d;
      opa_q   <= opa_d;
      opb_q   <= opb_d;
      rem_q   <= rem_d;
      msgn_q  <= msgn_d;
      qneg_q  <= qneg_d;
      rneg_q  <= rneg_d;
    end
  end

  assign busy   = (state_q != S_IDLE);
  assign done   = done_q;
  assign hi_out = hi_q;
  assign lo_out = lo_q;

endmodule

// File: tb/tb_hilo_mdu.sv
// Bench for hilo_mdu: directed vector table, multi-cycle corner sequences, random ops vs model.
// Latency: checks multiply and divide completion edge counts.
// Backpressure: exercises dropped requests while busy and acceptance in the done cycle.
module tb_hilo_mdu;

  localparam int W  = 32;
  localparam int ML = 2;
  localparam int DL = W + 1;

  localparam logic [2:0] OP_MULT  = 3'b000;
  localparam logic [2:0] OP_MULTU = 3'b001;
  localparam logic [2:0] OP_DIV   = 3'b010;
  localparam logic [2:0] OP_DIVU  = 3'b011;
  localparam logic [2:0] OP_MTHI  = 3'b100;
  localparam logic [2:0] OP_MTLO  = 3'b101;

  logic          clk, rst, op_valid, cancel;
  logic [2:0]    op;
  logic [W-1:0]  src_a, src_b;
  logic          busy, done;
  logic [W-1:0]  hi_out, lo_out;

  int errors;
  int checks;

  hilo_mdu #(.WIDTH(W), .MUL_LAT(ML)) dut (
    .clk      (clk),
    .rst      (rst),
    .op_valid (op_valid),
    .op       (op),
    .src_a    (src_a),
    .src_b    (src_b),
    .cancel   (cancel),
    .busy     (busy),
    .done     (done),
    .hi_out   (hi_out),
    .lo_out   (lo_out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [2:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] hi;
    logic [31:0] lo;
    int          lat;
  } vec_t;

  task automatic chk(input string nm, input int idx, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s[%0d]: got %h, expected %h", nm, idx, act, exp);
    end
  endtask

  // Issue one op, wait for completion (bounded), return edges from accept to done.
  task automatic run_op(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b,
                        input int idx, output int lat);
    logic [31:0] h0, l0;
    bit stable;
    @(negedge clk);
    h0 = hi_out; l0 = lo_out;
    op_valid = 1'b1; op = o; src_a = a; src_b = b;
    @(posedge clk); #1;
    op_valid = 1'b0;
    chk("done_low_after_accept", idx, done, 0);
    lat = 0;
    if (o >= 3'b100) begin
      chk("busy_mt", idx, busy, 0);
    end else begin
      chk("busy_on_accept", idx, busy, 1);
      stable = 1'b1;
      while (!done && lat < 100) begin
        @(posedge clk); lat++; #1;
        if (busy && (hi_out !== h0 || lo_out !== l0)) stable = 1'b0;
      end
      chk("hilo_stable_busy", idx, stable, 1);
      chk("busy_at_done", idx, busy, 0);
    end
  endtask

  function automatic logic [31:0] pick();
    case ($urandom_range(0, 7))
      0:       return 32'h0;
      1:       return 32'h80000000;
      2:       return 32'hFFFFFFFF;
      3:       return 32'h1;
      default: return $urandom;
    endcase
  endfunction

  vec_t vt[10];

  initial begin
    int lat, ndone;
    logic [31:0] h0, l0, mh, ml, ra, rb;
    logic [2:0]  ro;
    longint sa, sb, sq, sr, sp;
    logic [63:0] up;
    int elat;

    errors = 0; checks = 0;
    rst = 1'b1; op_valid = 1'b0; cancel = 1'b0; op = 3'b0; src_a = '0; src_b = '0;

    vt[0] = '{OP_MULT,  32'hFFFFFFFF, 32'd2,        32'hFFFFFFFF, 32'hFFFFFFFE, ML};
    vt[1] = '{OP_MULTU, 32'hFFFFFFFF, 32'd2,        32'h00000001, 32'hFFFFFFFE, ML};
    vt[2] = '{OP_DIV,   32'hFFFFFFF9, 32'd2,        32'hFFFFFFFF, 32'hFFFFFFFD, DL};
    vt[3] = '{OP_DIVU,  32'd7,        32'd2,        32'd1,        32'd3,        DL};
    vt[4] = '{OP_DIV,   32'h80000000, 32'hFFFFFFFF, 32'd0,        32'h80000000, DL};
    vt[5] = '{OP_DIV,   32'd100,      32'hFFFFFFF9, 32'd2,        32'hFFFFFFF2, DL};
    vt[6] = '{OP_DIV,   32'hFFFFFF9C, 32'd7,        32'hFFFFFFFE, 32'hFFFFFFF2, DL};
    vt[7] = '{OP_MULT,  32'hFFFFFFFD, 32'hFFFFFFFB, 32'd0,        32'd15,       ML};
    vt[8] = '{OP_DIVU,  32'hFFFFFFFF, 32'd16,       32'd15,       32'h0FFFFFFF, DL};
    vt[9] = '{OP_MULTU, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'h00000001, ML};

    // Reset state while rst is held.
    #12;
    chk("rst_hi", 0, hi_out, 0);
    chk("rst_lo", 0, lo_out, 0);
    chk("rst_busy", 0, busy, 0);
    chk("rst_done", 0, done, 0);
    @(negedge clk); rst = 1'b0;

    // Directed vector table; consecutive ops also exercise accept during the done cycle.
    for (int i = 0; i < 10; i++) begin
      run_op(vt[i].op, vt[i].a, vt[i].b, i, lat);
      chk("vec_latency", i, lat, vt[i].lat);
      chk("vec_hi", i, hi_out, vt[i].hi);
      chk("vec_lo", i, lo_out, vt[i].lo);
    end

    // MTHI, then DIVU by zero with a MTLO dropped while busy.
    run_op(OP_MTHI, 32'h12345678, 32'h0, 100, lat);
    chk("mthi", 100, hi_out, 32'h12345678);
    l0 = lo_out;
    @(negedge clk);
    op_valid = 1'b1; op = OP_DIVU; src_a = 32'd5; src_b = 32'd0;
    @(posedge clk); #1;
    op_valid = 1'b0;
    lat = 0;
    while (!done && lat < 100) begin
      @(negedge clk);
      if (lat == 3) begin
        op_valid = 1'b1; op = OP_MTLO; src_a = 32'hBEEF;
      end else begin
        op_valid = 1'b0;
      end
      @(posedge clk); lat++; #1;
    end
    op_valid = 1'b0;
    chk("div0_latency", 101, lat, DL);
    chk("div0_hi", 101, hi_out, 32'h12345678);
    chk("div0_lo", 101, lo_out, l0);
    @(posedge clk); #1;
    chk("done_one_cycle", 101, done, 0);

    // DIV 100/7 cancelled at the 10th edge, then an immediate MTLO.
    h0 = hi_out; l0 = lo_out;
    @(negedge clk);
    op_valid = 1'b1; op = OP_DIV; src_a = 32'd100; src_b = 32'd7;
    @(posedge clk); #1;
    op_valid = 1'b0;
    repeat (9) @(posedge clk);
    @(negedge clk); cancel = 1'b1;
    @(posedge clk); #1;
    cancel = 1'b0;
    chk("cancel_busy", 102, busy, 0);
    chk("cancel_done", 102, done, 0);
    chk("cancel_hi", 102, hi_out, h0);
    chk("cancel_lo", 102, lo_out, l0);
    op_valid = 1'b1; op = OP_MTLO; src_a = 32'hA;
    @(posedge clk); #1;
    op_valid = 1'b0;
    chk("mtlo_after_cancel", 102, lo_out, 32'hA);
    ndone = 0;
    repeat (40) begin
      @(posedge clk); #1;
      if (done) ndone++;
    end
    chk("cancel_no_done", 102, ndone, 0);

    // Cancel while idle blocks a MTHI.
    @(negedge clk);
    h0 = hi_out;
    op_valid = 1'b1; op = OP_MTHI; src_a = 32'hCAFE0000; cancel = 1'b1;
    @(posedge clk); #1;
    op_valid = 1'b0; cancel = 1'b0;
    chk("idle_cancel_hi", 103, hi_out, h0);
    chk("idle_cancel_busy", 103, busy, 0);

    // Cancel coinciding with the multiply commit edge wins.
    run_op(OP_MTLO, 32'h77, 32'h0, 104, lat);
    h0 = hi_out; l0 = lo_out;
    @(negedge clk);
    op_valid = 1'b1; op = OP_MULT; src_a = 32'd3; src_b = 32'd4;
    @(posedge clk); #1;
    op_valid = 1'b0;
    @(posedge clk);
    @(negedge clk); cancel = 1'b1;
    @(posedge clk); #1;
    cancel = 1'b0;
    chk("commit_cancel_busy", 104, busy, 0);
    chk("commit_cancel_hi", 104, hi_out, h0);
    chk("commit_cancel_lo", 104, lo_out, l0);
    @(posedge clk); #1;
    chk("commit_cancel_done", 104, done, 0);

    // Reset pulsed between edges during a multiply.
    run_op(OP_MTHI, 32'hAAAA5555, 32'h0, 105, lat);
    @(negedge clk);
    op_valid = 1'b1; op = OP_MULT; src_a = 32'd7; src_b = 32'd9;
    @(posedge clk); #1;
    op_valid = 1'b0;
    #2 rst = 1'b1;
    #1;
    chk("async_rst_hi", 105, hi_out, 0);
    chk("async_rst_lo", 105, lo_out, 0);
    chk("async_rst_busy", 105, busy, 0);
    chk("async_rst_done", 105, done, 0);
    @(negedge clk);
    rst = 1'b0;
    op_valid = 1'b1; op = OP_MTLO; src_a = 32'h55;
    @(posedge clk); #1;
    op_valid = 1'b0;
    chk("first_accept_after_rst", 105, lo_out, 32'h55);
    ndone = 0;
    repeat (6) begin
      if (done) ndone++;
      @(posedge clk); #1;
    end
    chk("rst_no_done", 105, ndone, 0);

    // Random ops against the arithmetic model.
    run_op(OP_MTHI, 32'h0, 32'h0, 200, lat);
    run_op(OP_MTLO, 32'h0, 32'h0, 200, lat);
    mh = 32'h0; ml = 32'h0;
    for (int i = 0; i < 80; i++) begin
      ro = 3'($urandom_range(0, 7));
      ra = pick();
      rb = pick();
      if ((ro == OP_DIV || ro == OP_DIVU) && $urandom_range(0, 9) == 0) rb = 32'h0;
      sa = longint'($signed(ra));
      sb = longint'($signed(rb));
      elat = 0;
      case (ro)
        OP_MULT: begin
          sp = sa * sb; mh = sp[63:32]; ml = sp[31:0]; elat = ML;
        end
        OP_MULTU: begin
          up = {32'h0, ra} * {32'h0, rb}; mh = up[63:32]; ml = up[31:0]; elat = ML;
        end
        OP_DIV: begin
          elat = DL;
          if (rb != 0) begin
            sq = sa / sb; sr = sa % sb; ml = sq[31:0]; mh = sr[31:0];
          end
        end
        OP_DIVU: begin
          elat = DL;
          if (rb != 0) begin
            ml = ra / rb; mh = ra % rb;
          end
        end
        OP_MTHI: mh = ra;
        OP_MTLO: ml = ra;
        default: ;
      endcase
      run_op(ro, ra, rb, 300 + i, lat);
      if (ro < 3'b100) chk("rnd_latency", 300 + i, lat, elat);
      chk("rnd_hi", 300 + i, hi_out, mh);
      chk("rnd_lo", 300 + i, lo_out, ml);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
